level_shifter_seq_ctrl: RTL and testbench
=========================================

// Module: level_shifter_seq_ctrl
// PURPOSE
//  Power sequencer for the DAC-path level shifter.
//  - Power-up order: VCC_LOW rail, then VCC_HIGH rail, then release the output isolation clamp.
//  - Power-down runs the same steps in reverse.
//  - Sits in top_level_DAC beside the level shifter.
//  - Drives the rail enables and the ISO_N clamp; reads the analog supply-good flags.
// PARAMETERS
//  CNT_W    8    dwell/timeout counter width; every count parameter must be <= 2**CNT_W-1
//  T_LOW    16   minimum dwell, in cycles, after switching VCC_LOW_EN
//  T_HIGH   16   minimum dwell, in cycles, after switching VCC_HIGH_EN
//  T_ISO    4    dwell, in cycles, after switching ISO_N
//  TIMEOUT  255  supply-good timeout, in cycles (used only with LS_SEQ_FAULT_EN)
// PORTS
//  CLK          in   1  system clock, rising edge
//  RST          in   1  asynchronous reset, active-high
//  PWR_REQ      in   1  1 = request shifter powered, 0 = request off
//  VCC_LOW_OK   in   1  low-rail good, asynchronous, 2-flop synchronised internally
//  VCC_HIGH_OK  in   1  high-rail good, asynchronous, 2-flop synchronised internally
//  FAULT_CLR    in   1  clears FAULT state (LS_SEQ_FAULT_EN only; ignored otherwise)
//  VCC_LOW_EN   out  1  low-rail enable
//  VCC_HIGH_EN  out  1  high-rail enable
//  ISO_N        out  1  0 = VOUT clamped/isolated, 1 = released
//  LS_READY     out  1  1 only in ON
//  BUSY         out  1  1 in any state other than OFF, ON or FAULT
//  FAULT        out  1  1 in FAULT; tied 0 without LS_SEQ_FAULT_EN
//  STATE        out  4  current state encoding
// BEHAVIOUR
//  RST: async; state=OFF, counter=0, synchronisers=0; every output 0.
//  Outputs are a Moore decode of the state register and change on the edge that changes state.
//  States and outputs:
//    OFF=0      all outputs 0
//    LOW_UP=1   VCC_LOW_EN=1
//    HIGH_UP=2  VCC_LOW_EN=1, VCC_HIGH_EN=1
//    RELEASE=3  both enables=1, ISO_N=1
//    ON=4       both enables=1, ISO_N=1, LS_READY=1
//    ISOLATE=5  both enables=1, ISO_N=0
//    HIGH_DN=6  VCC_LOW_EN=1
//    LOW_DN=7   all enables 0
//    FAULT=8    all enables 0, ISO_N=0, FAULT=1
//  Counter: cleared on every state change; increments once per cycle otherwise; saturates at 2**CNT_W-1.
//  Transitions:
//    OFF -> LOW_UP     when PWR_REQ=1
//    LOW_UP -> HIGH_UP when cnt>=T_LOW-1 and synced VCC_LOW_OK=1
//    HIGH_UP -> RELEASE when cnt>=T_HIGH-1 and synced VCC_HIGH_OK=1
//    RELEASE -> ON     when cnt>=T_ISO-1
//    ON -> ISOLATE     when PWR_REQ=0
//    ISOLATE -> HIGH_DN when cnt>=T_ISO-1
//    HIGH_DN -> LOW_DN when cnt>=T_HIGH-1
//    LOW_DN -> OFF     when cnt>=T_LOW-1
//  Abort on PWR_REQ=0 during power-up; this takes priority over the advance condition:
//    LOW_UP -> LOW_DN, HIGH_UP -> HIGH_DN, RELEASE -> ISOLATE.
//  PWR_REQ=1 during power-down is ignored; the sequence completes to OFF, then restarts next cycle.
//  Without LS_SEQ_FAULT_EN, LOW_UP and HIGH_UP wait indefinitely for the synced OK flags.
//  OK flags are not examined in ON or in the power-down states.
// CONFIGURATION
//  LS_SEQ_FAULT_EN defined:
//    - LOW_UP/HIGH_UP: cnt==TIMEOUT with the synced OK flag still 0 -> FAULT.
//    - ON: synced VCC_LOW_OK=0 or VCC_HIGH_OK=0 -> FAULT on the next edge.
//    - FAULT -> OFF only when FAULT_CLR=1 and PWR_REQ=0 in the same cycle.
//    - Fault checks take priority over the abort and advance conditions.
//  LS_SEQ_FAULT_EN undefined:
//    - No FAULT state and no timeout; FAULT output tied 0; FAULT_CLR unused.
// TESTING (defaults; OK inputs held 1 unless noted; e0 = edge that samples PWR_REQ=1)
//  1 Power-up: VCC_LOW_EN=1 after e0; VCC_HIGH_EN=1 after e16; ISO_N=1 after e32; LS_READY=1 after e36; BUSY=0 from e36.
//  2 Power-down from ON, PWR_REQ->0 at edge d0: ISO_N=0 and LS_READY=0 after d0; VCC_HIGH_EN=0 after d4; VCC_LOW_EN=0 after d20; STATE=OFF after d36.
//  3 Abort: PWR_REQ->0 on the 5th cycle of HIGH_UP -> next edge HIGH_DN; ISO_N never 1; OFF reached 32 cycles later.
//  4 Slow rail: VCC_LOW_OK rises 40 cycles after e0 -> HIGH_UP entered on the 3rd edge after the rise (2-flop sync); FAULT stays 0.
//  5 Fault (LS_SEQ_FAULT_EN): VCC_HIGH_OK stuck 0 -> FAULT=1 once cnt reaches 255 in HIGH_UP, enables 0; FAULT_CLR with PWR_REQ=1 ignored; FAULT_CLR with PWR_REQ=0 -> OFF.
//     Same stimulus without the macro -> remains in HIGH_UP indefinitely, FAULT=0.
//  6 RST pulse mid-ON, between clock edges -> all outputs 0 immediately (async); STATE=OFF; re-sequences from LOW_UP after RST release with PWR_REQ=1.

Source files
------------

// File: rtl/level_shifter_seq_ctrl.sv
// Power sequencer for the DAC-path level shifter: VCC_LOW, then VCC_HIGH, then ISO_N release; reverse order to power down.
// Optional macro LS_SEQ_FAULT_EN adds the supply-good timeout / rail-loss FAULT state.
module level_shifter_seq_ctrl #(
    parameter int CNT_W   = 8,
    parameter int T_LOW   = 16,
    parameter int T_HIGH  = 16,
    parameter int T_ISO   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PWR_REQ,
    input  logic       VCC_LOW_OK,
    input  logic       VCC_HIGH_OK,
    input  logic       FAULT_CLR,
    output logic       VCC_LOW_EN,
    output logic       VCC_HIGH_EN,
    output logic       ISO_N,
    output logic       LS_READY,
    output logic       BUSY,
    output logic       FAULT,
    output logic [3:0] STATE
);

    typedef enum logic [3:0] {
        S_OFF     = 4'd0,
        S_LOW_UP  = 4'd1,
        S_HIGH_UP = 4'd2,
        S_RELEASE = 4'd3,
        S_ON      = 4'd4,
        S_ISOLATE = 4'd5,
        S_HIGH_DN = 4'd6,
        S_LOW_DN  = 4'd7,
        S_FAULT   = 4'd8
    } state_t;

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(T_LOW - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(T_HIGH - 1);
    localparam logic [CNT_W-1:0] ISO_LAST  = CNT_W'(T_ISO - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       low_sync_q, high_sync_q;
    logic             low_ok, high_ok;
    logic             low_en_q, high_en_q, iso_n_q, ready_q, busy_q;

    assign low_ok  = low_sync_q[1];
    assign high_ok = high_sync_q[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            low_sync_q  <= 2'b00;
            high_sync_q <= 2'b00;
        end else begin
            low_sync_q  <= {low_sync_q[0], VCC_LOW_OK};
            high_sync_q <= {high_sync_q[0], VCC_HIGH_OK};
        end
    end

`ifdef LS_SEQ_FAULT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);
    logic fault_q;
`else
    logic [CNT_W-1:0] unused_timeout;
    logic             unused_fault_clr;
    assign unused_timeout   = CNT_W'(TIMEOUT);
    assign unused_fault_clr = FAULT_CLR;
`endif

    // Later assignments in each arm override earlier ones, so fault checks win over abort, abort over advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OFF: if (PWR_REQ) state_d = S_LOW_UP;
            S_LOW_UP: begin
                if (!PWR_REQ) state_d = S_LOW_DN;
                else if (cnt_q >= LOW_LAST && low_ok) state_d = S_HIGH_UP;
`ifdef LS_SEQ_FAULT_EN
                if (cnt_q == TO_LAST && !low_ok) state_d = S_FAULT;
`endif
            end
            S_HIGH_UP: begin
                if (!PWR_REQ) state_d = S_HIGH_DN;
                else if (cnt_q >= HIGH_LAST && high_ok) state_d = S_RELEASE;
`ifdef LS_SEQ_FAULT_EN
                if (cnt_q == TO_LAST && !high_ok) state_d = S_FAULT;
`endif
            end
            S_RELEASE: begin
                if (!PWR_REQ) state_d = S_ISOLATE;
                else if (cnt_q >= ISO_LAST) state_d = S_ON;
            end
            S_ON: begin
                if (!PWR_REQ) state_d = S_ISOLATE;
`ifdef LS_SEQ_FAULT_EN
                if (!low_ok || !high_ok) state_d = S_FAULT;
`endif
            end
            S_ISOLATE: if (cnt_q >= ISO_LAST) state_d = S_HIGH_DN;
            S_HIGH_DN: if (cnt_q >= HIGH_LAST) state_d = S_LOW_DN;
            S_LOW_DN:  if (cnt_q >= LOW_LAST) state_d = S_OFF;
`ifdef LS_SEQ_FAULT_EN
            S_FAULT:   if (FAULT_CLR && !PWR_REQ) state_d = S_OFF;
`endif
            default:   state_d = S_OFF;
        endcase
    end

    always_comb begin
        if (state_d != state_q) cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else cnt_d = cnt_q + 1'b1;
    end

    // Outputs are decoded from the next state so they switch on the same edge as STATE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            low_en_q  <= 1'b0;
            high_en_q <= 1'b0;
            iso_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef LS_SEQ_FAULT_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            low_en_q  <= state_d inside {S_LOW_UP, S_HIGH_UP, S_RELEASE, S_ON, S_ISOLATE, S_HIGH_DN};
            high_en_q <= state_d inside {S_HIGH_UP, S_RELEASE, S_ON, S_ISOLATE};
            iso_n_q   <= state_d inside {S_RELEASE, S_ON};
            ready_q   <= (state_d == S_ON);
            busy_q    <= !(state_d inside {S_OFF, S_ON, S_FAULT});
`ifdef LS_SEQ_FAULT_EN
            fault_q   <= (state_d == S_FAULT);
`endif
        end
    end

    assign VCC_LOW_EN  = low_en_q;
    assign VCC_HIGH_EN = high_en_q;
    assign ISO_N       = iso_n_q;
    assign LS_READY    = ready_q;
    assign BUSY        = busy_q;
    assign STATE       = state_q;
`ifdef LS_SEQ_FAULT_EN
    assign FAULT       = fault_q;
`else
    assign FAULT       = 1'b0;
`endif

endmodule

// File: tb/tb_level_shifter_seq_ctrl.sv
// Scoreboard bench for level_shifter_seq_ctrl: expected states are queued per edge and popped as edges occur.
module tb_level_shifter_seq_ctrl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PWR_REQ = 1'b0;
    logic       VCC_LOW_OK = 1'b1;
    logic       VCC_HIGH_OK = 1'b1;
    logic       FAULT_CLR = 1'b0;
    logic       VCC_LOW_EN, VCC_HIGH_EN, ISO_N, LS_READY, BUSY, FAULT;
    logic [3:0] STATE;

    level_shifter_seq_ctrl dut (
        .CLK(CLK), .RST(RST), .PWR_REQ(PWR_REQ), .VCC_LOW_OK(VCC_LOW_OK),
        .VCC_HIGH_OK(VCC_HIGH_OK), .FAULT_CLR(FAULT_CLR), .VCC_LOW_EN(VCC_LOW_EN),
        .VCC_HIGH_EN(VCC_HIGH_EN), .ISO_N(ISO_N), .LS_READY(LS_READY), .BUSY(BUSY),
        .FAULT(FAULT), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         edge_n;
        logic [3:0] st;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    wire [5:0] dut_outs = {VCC_LOW_EN, VCC_HIGH_EN, ISO_N, LS_READY, BUSY, FAULT};

    // {low_en, high_en, iso_n, ready, busy, fault} per state
    function automatic logic [5:0] model_outs(logic [3:0] st);
        case (st)
            4'd0:    return 6'b000000;
            4'd1:    return 6'b100010;
            4'd2:    return 6'b110010;
            4'd3:    return 6'b111010;
            4'd4:    return 6'b111100;
            4'd5:    return 6'b110010;
            4'd6:    return 6'b100010;
            4'd7:    return 6'b000010;
            4'd8:    return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic push_exp(int e, logic [3:0] st, string tag);
        exp_t x;
        x.edge_n = e; x.st = st; x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (STATE !== 4'd0 || dut_outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: state=%0d outs=%b, required state=0 outs=000000", STATE, dut_outs);
        end
        @(negedge CLK) RST = 1'b0;
        push_exp(0, 4'd0, "reset_idle0");
        push_exp(3, 4'd0, "reset_idle3");
        for (int k = 0; k <= 3; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
        end
    endtask

    task automatic test_power_up();
        push_exp(0, 4'd1, "up_low_en");    push_exp(15, 4'd1, "up_low_dwell");
        push_exp(16, 4'd2, "up_high_en");  push_exp(31, 4'd2, "up_high_dwell");
        push_exp(32, 4'd3, "up_release");  push_exp(35, 4'd3, "up_iso_dwell");
        push_exp(36, 4'd4, "up_ready");    push_exp(40, 4'd4, "up_hold_on");
        PWR_REQ = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
        end
    endtask

    task automatic test_power_down();
        push_exp(0, 4'd5, "dn_isolate");   push_exp(3, 4'd5, "dn_iso_dwell");
        push_exp(4, 4'd6, "dn_high_off");  push_exp(19, 4'd6, "dn_high_dwell");
        push_exp(20, 4'd7, "dn_low_off");  push_exp(35, 4'd7, "dn_low_dwell");
        push_exp(36, 4'd0, "dn_off");
        PWR_REQ = 1'b0;
        for (int k = 0; k <= 38; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
        end
    endtask

    task automatic test_abort();
        logic iso_seen;
        iso_seen = 1'b0;
        push_exp(16, 4'd2, "ab_high_up"); push_exp(20, 4'd2, "ab_high_up5");
        push_exp(21, 4'd6, "ab_high_dn"); push_exp(36, 4'd6, "ab_high_dwell");
        push_exp(37, 4'd7, "ab_low_dn");  push_exp(52, 4'd7, "ab_low_dwell");
        push_exp(53, 4'd0, "ab_off");
        PWR_REQ = 1'b1;
        for (int k = 0; k <= 55; k++) begin
            step();
            if (ISO_N === 1'b1) iso_seen = 1'b1;
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
            if (k == 20) PWR_REQ = 1'b0;
        end
        checks++;
        if (iso_seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_iso_never_released: iso_seen=%b, required 0", iso_seen);
        end
    endtask

    task automatic test_slow_rail();
        VCC_LOW_OK = 1'b0;
        push_exp(20, 4'd1, "slow_wait");  push_exp(42, 4'd1, "slow_sync2");
        push_exp(43, 4'd2, "slow_high_up"); push_exp(45, 4'd6, "slow_abort");
        push_exp(77, 4'd0, "slow_off");
        PWR_REQ = 1'b1;
        for (int k = 0; k <= 78; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
            if (k == 40) VCC_LOW_OK = 1'b1;
            if (k == 44) PWR_REQ = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        push_exp(36, 4'd4, "b2b_on");      push_exp(39, 4'd5, "b2b_isolate");
        push_exp(43, 4'd6, "b2b_req_ignored"); push_exp(59, 4'd7, "b2b_low_dn");
        push_exp(75, 4'd0, "b2b_off");     push_exp(76, 4'd1, "b2b_restart");
        push_exp(112, 4'd4, "b2b_on_again");
        PWR_REQ = 1'b1;
        for (int k = 0; k <= 112; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
            if (k == 38) PWR_REQ = 1'b0;
            if (k == 41) PWR_REQ = 1'b1;
        end
    endtask

    task automatic test_reset_mid_on();
        #2 RST = 1'b1;
        #1;
        checks++;
        if (STATE !== 4'd0 || dut_outs !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: state=%0d outs=%b, required state=0 outs=000000", STATE, dut_outs);
        end
        #2 RST = 1'b0;
        push_exp(0, 4'd1, "rst_low_up");  push_exp(15, 4'd1, "rst_low_dwell");
        push_exp(16, 4'd2, "rst_high_up"); push_exp(18, 4'd6, "rst_abort");
        push_exp(50, 4'd0, "rst_off");
        for (int k = 0; k <= 51; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
            if (k == 17) PWR_REQ = 1'b0;
        end
    endtask

    task automatic test_stuck_high_rail();
        int last;
        VCC_HIGH_OK = 1'b0;
        push_exp(16, 4'd2, "stuck_high_up"); push_exp(271, 4'd2, "stuck_cnt254");
`ifdef LS_SEQ_FAULT_EN
        push_exp(272, 4'd8, "fault_timeout"); push_exp(278, 4'd8, "fault_clr_ignored");
        push_exp(279, 4'd0, "fault_cleared");
        last = 281;
`else
        push_exp(272, 4'd2, "no_fault_wait"); push_exp(400, 4'd2, "no_fault_wait_long");
        push_exp(401, 4'd6, "no_fault_abort"); push_exp(433, 4'd0, "no_fault_off");
        last = 435;
`endif
        PWR_REQ = 1'b1;
        for (int k = 0; k <= last; k++) begin
            step();
            while (sb_q.size() > 0 && sb_q[0].edge_n == k) begin
                exp_t x;
                x = sb_q.pop_front();
                checks++;
                if (STATE !== x.st || dut_outs !== model_outs(x.st)) begin
                    errors++;
                    $display("FAIL %s edge %0d: state=%0d outs=%b, required state=%0d outs=%b", x.tag, k, STATE, dut_outs, x.st, model_outs(x.st));
                end
            end
`ifdef LS_SEQ_FAULT_EN
            if (k == 275) FAULT_CLR = 1'b1;
            if (k == 278) PWR_REQ = 1'b0;
            if (k == 279) FAULT_CLR = 1'b0;
`else
            if (k == 300) FAULT_CLR = 1'b1;
            if (k == 302) FAULT_CLR = 1'b0;
            if (k == 400) PWR_REQ = 1'b0;
`endif
        end
        VCC_HIGH_OK = 1'b1;
    endtask

    task automatic test_scoreboard_drained();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d entries left, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_abort();
        test_slow_rail();
        test_back_to_back();
        test_reset_mid_on();
        test_stuck_high_rail();
        test_scoreboard_drained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
